// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction-fetch stage and its fetch queue.
package ifu_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h1c000000;
  localparam int          INST_W       = 32;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
    logic              filled;
  } fq_entry_t;

  // Pointers carry one wrap bit above the index so full and empty are distinguishable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// In-order fetch queue: entries allocated at request handshake, filled by response, popped by IDU.
// Zero-latency status outputs; callers must not alloc when full, fill when nothing unfilled, or pop when head unfilled.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              alloc,
  input  logic [31:0]       alloc_pc,
  input  logic              fill,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              pop,
  output fq_entry_t         head,
  output logic              head_filled,
  output logic [CNT_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  unfilled,
  output logic [CNT_W-1:0]  filled
);

  localparam int IDX_W = CNT_W - 1;

  fq_entry_t        mem [DEPTH];
  logic [CNT_W-1:0] alloc_ptr;
  logic [CNT_W-1:0] fill_ptr;
  logic [CNT_W-1:0] pop_ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      pop_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      pop_ptr   <= '0;
    end else begin
      // alloc targets a free slot and fill an allocated one, so the two never collide
      if (alloc) begin
        mem[alloc_ptr[IDX_W-1:0]].pc     <= alloc_pc;
        mem[alloc_ptr[IDX_W-1:0]].inst   <= '0;
        mem[alloc_ptr[IDX_W-1:0]].filled <= 1'b0;
        alloc_ptr                        <= alloc_ptr + 1'b1;
      end
      if (fill) begin
        mem[fill_ptr[IDX_W-1:0]].inst   <= fill_inst;
        mem[fill_ptr[IDX_W-1:0]].filled <= 1'b1;
        fill_ptr                        <= fill_ptr + 1'b1;
      end
      if (pop) begin
        pop_ptr <= pop_ptr + 1'b1;
      end
    end
  end

  assign head        = mem[pop_ptr[IDX_W-1:0]];
  assign head_filled = (fill_ptr != pop_ptr);
  assign occupancy   = alloc_ptr - pop_ptr;
  assign unfilled    = alloc_ptr - fill_ptr;
  assign filled      = fill_ptr - pop_ptr;

endmodule

// File: rtl/ifu_prefetch.sv
// Prefetching fetch stage: up to DEPTH requests in flight or buffered; fs_valid one cycle after data_ok.
// Requests held stable until addr_ok; issue stalls when buffered+outstanding hits DEPTH. IFU_PERF_CNT_EN adds perf counters.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              inst_req,
  output logic [31:0]       inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [INST_W-1:0] inst_rdata,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  output logic              fs_valid,
  output logic [INST_W-1:0] fs_inst,
  output logic [31:0]       fs_pc,
  input  logic              ds_allow_in
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_X = (CNT_W+1)'(DEPTH);

  logic             issue_en;
  logic [31:0]      fetch_pc;
  logic [31:0]      redirect_pc;
  logic             redirect_pend;
  logic [CNT_W-1:0] cancel_cnt;
  logic [CNT_W-1:0] cancel_nxt;

  fq_entry_t        head;
  logic             head_filled;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] unfilled;
  logic [CNT_W-1:0] filled;

  logic             hs;
  logic             hs_wrong;
  logic             alloc;
  logic             resp_drop;
  logic             fill;
  logic             pop;
  logic [CNT_W:0]   budget;

  // Cancelled responses still occupy bus slots, so they count against capacity.
  assign budget    = {1'b0, cancel_cnt} + {1'b0, occupancy};
  assign inst_req  = issue_en && (occupancy < DEPTH_C) && (budget < DEPTH_X);
  assign inst_addr = fetch_pc;

  assign hs        = inst_req && inst_addr_ok;
  assign hs_wrong  = hs && (redirect_pend || br_taken);
  assign alloc     = hs && !hs_wrong;
  assign resp_drop = inst_data_ok && (cancel_cnt != '0);
  assign fill      = inst_data_ok && !resp_drop;
  assign pop       = head_filled && ds_allow_in;

  always_comb begin
    cancel_nxt = cancel_cnt - CNT_W'(resp_drop) + CNT_W'(hs_wrong);
    // on flush every entry still waiting for data becomes a response to discard
    if (br_taken) begin
      cancel_nxt = cancel_nxt + unfilled - CNT_W'(fill);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issue_en      <= 1'b0;
      fetch_pc      <= PC_RESET;
      redirect_pc   <= '0;
      redirect_pend <= 1'b0;
      cancel_cnt    <= '0;
    end else begin
      issue_en   <= 1'b1;
      cancel_cnt <= cancel_nxt;
      if (br_taken) begin
        // a raised request is never withdrawn; park the target until it is accepted
        if (inst_req && !inst_addr_ok) begin
          redirect_pend <= 1'b1;
          redirect_pc   <= br_target;
        end else begin
          redirect_pend <= 1'b0;
          fetch_pc      <= br_target;
        end
      end else if (hs) begin
        redirect_pend <= 1'b0;
        fetch_pc      <= redirect_pend ? redirect_pc : fetch_pc + 32'd4;
      end
    end
  end

  ifu_fetch_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fq (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (br_taken),
    .alloc       (alloc),
    .alloc_pc    (fetch_pc),
    .fill        (fill),
    .fill_inst   (inst_rdata),
    .pop         (pop),
    .head        (head),
    .head_filled (head_filled),
    .occupancy   (occupancy),
    .unfilled    (unfilled),
    .filled      (filled)
  );

  assign fs_valid = head_filled;
  assign fs_inst  = head.inst;
  assign fs_pc    = head.pc;

`ifdef IFU_PERF_CNT_EN
  logic [CNT_W-1:0] flush_filled;

  // entries holding data at the flush edge, minus the one IDU takes in that cycle
  assign flush_filled = filled + CNT_W'(fill) - CNT_W'(pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(pop);
      perf_drop_cnt  <= perf_drop_cnt + 32'(resp_drop)
                        + (br_taken ? 32'(flush_filled) : 32'd0);
    end
  end
`endif

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
    inst_data_ok |-> (cancel_cnt != '0 || unfilled != '0));

  a_req_stable: assert property (@(posedge clk) disable iff (!resetn)
    (inst_req && !inst_addr_ok) |=> (inst_req && $stable(inst_addr)));

endmodule
